// File: rtl/speed_pkg.sv
// Shared constants, the step-event encoding and the nominal-divisor helper
// for the speech synthesizer playback-speed controller.
package speed_pkg;

    // Default board timing and divisor limits
    localparam int unsigned DEF_CLK_HZ        = 32'd25000000;
    localparam int unsigned DEF_NOMINAL_HZ    = 32'd7200;
    localparam int unsigned DEF_STEP          = 32'd16;
    localparam int unsigned DEF_MIN_DIV       = 32'd1000;
    localparam int unsigned DEF_MAX_DIV       = 32'd10000;
    localparam int unsigned DEF_REPEAT_DELAY  = 32'd12500000;
    localparam int unsigned DEF_REPEAT_PERIOD = 32'd2500000;

    // What the priority logic decided to do with the divisor this cycle
    typedef enum logic [1:0] {
        EVT_NONE    = 2'd0,
        EVT_INC     = 2'd1,
        EVT_DEC     = 2'd2,
        EVT_NOMINAL = 2'd3
    } step_evt_t;

    // Clock cycles per sample at the nominal rate (truncating division)
    function automatic int unsigned calc_nominal_div(input int unsigned clk_hz,
                                                     input int unsigned nominal_hz);
        if (nominal_hz == 32'd0) begin
            return 32'd0;
        end else begin
            return clk_hz / nominal_hz;
        end
    endfunction

endpackage

// File: rtl/btn_step_gen.sv
// One button channel: 2-flop synchroniser, rising-edge detector and the
// hold counter that produces auto-repeat step pulses while the button is held.
module btn_step_gen
    import speed_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic hold_clr,
    output logic level_s,
    output logic step
);

    localparam int unsigned MAX_TARGET = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int          CW         = (MAX_TARGET < 32'd2) ? 1 : $clog2(MAX_TARGET + 32'd1);
    localparam bit          REPEAT_EN  = (REPEAT_DELAY > 32'd0);
    localparam logic [CW-1:0] DELAY_C  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PERIOD_C = CW'(REPEAT_PERIOD);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    logic          meta_r;
    logic          level_r;
    logic          prev_r;
    logic [CW-1:0] hold_cnt_r;
    logic          repeating_r;
    logic [CW-1:0] target;
    logic          fire;
    logic          edge_s;

    assign level_s = level_r;
    assign edge_s  = level_r & ~prev_r;
    assign step    = edge_s | fire;

    // Synchronise the raw button level and keep last level for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r  <= 1'b0;
            level_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            meta_r  <= btn;
            level_r <= meta_r;
            prev_r  <= level_r;
        end
    end

    // Auto-repeat fires when the hold count reaches the first delay, then each period
    always_comb begin
        target = repeating_r ? PERIOD_C : DELAY_C;
        fire   = 1'b0;
        if (REPEAT_EN && level_r && !hold_clr && (hold_cnt_r == target)) begin
            fire = 1'b1;
        end else begin
            fire = 1'b0;
        end
    end

    // Hold counter: cycles since the press (or since the last repeat step)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt_r  <= '0;
            repeating_r <= 1'b0;
        end else if (!level_r || hold_clr || !REPEAT_EN) begin
            hold_cnt_r  <= '0;
            repeating_r <= 1'b0;
        end else if (fire) begin
            hold_cnt_r  <= ONE_C;
            repeating_r <= 1'b1;
        end else begin
            hold_cnt_r  <= hold_cnt_r + ONE_C;
            repeating_r <= repeating_r;
        end
    end

endmodule

// File: rtl/speed_step_ctrl.sv
// Playback-speed controller: steps the sample divisor up/down from the
// buttons (with auto-repeat), saturates at the bounds, and generates the
// sample-rate strobe from the current divisor.
module speed_step_ctrl
    import speed_pkg::*;
#(
    parameter int          WIDTH         = 32,
    parameter int unsigned CLK_HZ        = DEF_CLK_HZ,
    parameter int unsigned NOMINAL_HZ    = DEF_NOMINAL_HZ,
    parameter int unsigned STEP          = DEF_STEP,
    parameter int unsigned MIN_DIV       = DEF_MIN_DIV,
    parameter int unsigned MAX_DIV       = DEF_MAX_DIV,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             down,
    input  logic             up,
    input  logic             normal,
    output logic [WIDTH-1:0] speed_out_val,
    output logic             sample_tick,
    output logic             at_min,
    output logic             at_max
);

    localparam int unsigned      NOMINAL_DIV = calc_nominal_div(CLK_HZ, NOMINAL_HZ);
    localparam logic [WIDTH-1:0] NOM_W       = WIDTH'(NOMINAL_DIV);
    localparam logic [WIDTH-1:0] MIN_W       = WIDTH'(MIN_DIV);
    localparam logic [WIDTH-1:0] MAX_W       = WIDTH'(MAX_DIV);
    localparam logic [WIDTH-1:0] ONE_W       = WIDTH'(1);
    localparam logic [WIDTH:0]   STEP_X      = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   MIN_X       = (WIDTH+1)'(MIN_DIV);
    localparam logic [WIDTH:0]   MAX_X       = (WIDTH+1)'(MAX_DIV);

    // Divisor plus one step, saturated at the upper bound (no wrap in WIDTH+1 bits)
    function automatic logic [WIDTH-1:0] clamp_inc(input logic [WIDTH-1:0] cur);
        logic [WIDTH:0] sum;
        sum = {1'b0, cur} + STEP_X;
        if (sum > MAX_X) begin
            return MAX_W;
        end else begin
            return sum[WIDTH-1:0];
        end
    endfunction

    // Divisor minus one step, saturated at the lower bound (never goes negative)
    function automatic logic [WIDTH-1:0] clamp_dec(input logic [WIDTH-1:0] cur);
        logic [WIDTH:0] diff;
        diff = {1'b0, cur} - STEP_X;
        if ({1'b0, cur} < (MIN_X + STEP_X)) begin
            return MIN_W;
        end else begin
            return diff[WIDTH-1:0];
        end
    endfunction

    logic             normal_meta_r;
    logic             normal_s;
    logic             up_s;
    logic             up_step;
    logic             down_s;
    logic             down_step;
    logic             hold_clr;
    step_evt_t        evt;
    logic [WIDTH-1:0] div_r;
    logic [WIDTH-1:0] next_div;
    logic [WIDTH-1:0] cnt_r;
    logic             tick_r;

    // Return-to-nominal and simultaneous presses both freeze auto-repeat
    assign hold_clr = normal_s | (up_s & down_s);

    btn_step_gen #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_up_gen (
        .clk      (clk),
        .reset    (reset),
        .btn      (up),
        .hold_clr (hold_clr),
        .level_s  (up_s),
        .step     (up_step)
    );

    btn_step_gen #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_down_gen (
        .clk      (clk),
        .reset    (reset),
        .btn      (down),
        .hold_clr (hold_clr),
        .level_s  (down_s),
        .step     (down_step)
    );

    // Synchronise the return-to-nominal level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            normal_meta_r <= 1'b0;
            normal_s      <= 1'b0;
        end else begin
            normal_meta_r <= normal;
            normal_s      <= normal_meta_r;
        end
    end

    // Pick this cycle's action: nominal beats both-held beats up beats down
    always_comb begin
        evt = EVT_NONE;
        if (normal_s) begin
            evt = EVT_NOMINAL;
        end else if (up_s && down_s) begin
            evt = EVT_NONE;
        end else if (up_step) begin
            evt = EVT_INC;
        end else if (down_step) begin
            evt = EVT_DEC;
        end else begin
            evt = EVT_NONE;
        end
    end

    // Next divisor value, clamped before it reaches the register
    always_comb begin
        next_div = div_r;
        case (evt)
            EVT_NOMINAL: next_div = NOM_W;
            EVT_INC:     next_div = clamp_inc(div_r);
            EVT_DEC:     next_div = clamp_dec(div_r);
            default:     next_div = div_r;
        endcase
    end

    // Divisor register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_r <= NOM_W;
        end else begin
            div_r <= next_div;
        end
    end

    // Sample-period counter; >= compare lets a shrunken divisor tick right away
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else if (cnt_r >= (div_r - ONE_W)) begin
            cnt_r  <= '0;
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + ONE_W;
            tick_r <= 1'b0;
        end
    end

    assign speed_out_val = div_r;
    assign sample_tick   = tick_r;
    assign at_min        = (div_r == MIN_W);
    assign at_max        = (div_r == MAX_W);

endmodule

// File: tb/tb_speed_step_ctrl.sv
// Randomised bench for speed_step_ctrl, checked cycle by cycle against a
// behavioural model built from the button/divisor/tick rules.
module tb_speed_step_ctrl;

    localparam int WIDTH   = 32;
    localparam int STEP    = 16;
    localparam int MIN_DIV = 3440;
    localparam int MAX_DIV = 3504;
    localparam int RD      = 8;
    localparam int RP      = 4;
    localparam int NOM     = 25000000 / 7200;

    logic             clk = 1'b0;
    logic             reset;
    logic             up;
    logic             down;
    logic             normal;
    logic [WIDTH-1:0] speed_out_val;
    logic             sample_tick;
    logic             at_min;
    logic             at_max;

    always #5 clk = ~clk;

    speed_step_ctrl #(
        .WIDTH         (WIDTH),
        .CLK_HZ        (32'd25000000),
        .NOMINAL_HZ    (32'd7200),
        .STEP          (32'd16),
        .MIN_DIV       (32'd3440),
        .MAX_DIV       (32'd3504),
        .REPEAT_DELAY  (32'd8),
        .REPEAT_PERIOD (32'd4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .down          (down),
        .up            (up),
        .normal        (normal),
        .speed_out_val (speed_out_val),
        .sample_tick   (sample_tick),
        .at_min        (at_min),
        .at_max        (at_max)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int mdiv;
    int mcnt;
    bit mtick;
    int hu;
    int hd;
    bit u1, u2, u3, d1, d2, d3, n1, n2;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mdiv  = NOM;
        mcnt  = 0;
        mtick = 1'b0;
        hu    = 0;
        hd    = 0;
        u1 = 1'b0; u2 = 1'b0; u3 = 1'b0;
        d1 = 1'b0; d2 = 1'b0; d3 = 1'b0;
        n1 = 1'b0; n2 = 1'b0;
    endtask

    // Step event for a held button: press edge, then RD after it, then every RP
    function automatic bit step_event(input bit lvl, input bit prev, input bit clr, input int held);
        if (!lvl || clr) return 1'b0;
        if (!prev) return 1'b1;
        return (held >= RD) && (((held - RD) % RP) == 0);
    endfunction

    // Advance the model by one rising clock edge
    task automatic model_edge();
        bit lu, pu, ld, pd, ln, clr, ue, de, t;
        if (reset) begin
            model_reset();
        end else begin
            // buttons are seen two edges late through the synchronisers
            lu = u2; pu = u3; ld = d2; pd = d3; ln = n2;
            t     = (mcnt >= mdiv - 1);
            mtick = t;
            mcnt  = t ? 0 : mcnt + 1;
            clr   = ln || (lu && ld);
            ue    = step_event(lu, pu, clr, hu);
            de    = step_event(ld, pd, clr, hd);
            if (ln) mdiv = NOM;
            else if (lu && ld) mdiv = mdiv;
            else if (ue) mdiv = (mdiv + STEP > MAX_DIV) ? MAX_DIV : mdiv + STEP;
            else if (de) mdiv = (mdiv - STEP < MIN_DIV) ? MIN_DIV : mdiv - STEP;
            hu = (lu && !clr) ? hu + 1 : 0;
            hd = (ld && !clr) ? hd + 1 : 0;
            u3 = u2; u2 = u1; u1 = up;
            d3 = d2; d2 = d1; d1 = down;
            n2 = n1; n1 = normal;
        end
    endtask

    task automatic check_outputs();
        check_val("speed_out_val", speed_out_val, mdiv);
        check_val("sample_tick", sample_tick, mtick);
        check_val("at_min", at_min, (mdiv == MIN_DIV));
        check_val("at_max", at_max, (mdiv == MAX_DIV));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_outputs();
        end
    endtask

    // Asynchronous reset taken mid-cycle: outputs must drop before any clock edge
    task automatic mid_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        run($urandom_range(1, 4));
        reset = 1'b0;
    endtask

    task automatic random_segment();
        int kind;
        int len;
        kind = $urandom_range(0, 8);
        len  = $urandom_range(1, 30);
        case (kind)
            0: begin up = 1'b1; run($urandom_range(1, 3)); up = 1'b0; end
            1: begin down = 1'b1; run($urandom_range(1, 3)); down = 1'b0; end
            2: begin up = 1'b1; run(len); up = 1'b0; end
            3: begin down = 1'b1; run(len); down = 1'b0; end
            4: begin
                up = 1'b1; down = 1'b1; run(len);
                if ($urandom_range(0, 1) == 0) down = 1'b0; else up = 1'b0;
                run($urandom_range(3, 20));
                up = 1'b0; down = 1'b0;
            end
            5: begin
                normal = 1'b1; run(1);
                up = 1'b1; run($urandom_range(1, 4));
                up = 1'b0; run($urandom_range(0, 3));
                normal = 1'b0;
            end
            6: run($urandom_range(50, 1500));
            7: mid_reset();
            default: begin
                up = $urandom_range(0, 1) == 1; down = $urandom_range(0, 1) == 1;
                normal = $urandom_range(0, 3) == 0;
                run(len);
                up = 1'b0; down = 1'b0; normal = 1'b0;
            end
        endcase
        run($urandom_range(1, 10));
    endtask

    initial begin
        reset  = 1'b1;
        up     = 1'b0;
        down   = 1'b0;
        normal = 1'b0;
        model_reset();
        #1;
        check_outputs();
        run(3);
        reset = 1'b0;

        // idle: three full nominal sample periods
        run(3 * NOM + 20);

        // four single-cycle up presses: saturate at the upper bound
        for (int k = 0; k < 4; k++) begin
            up = 1'b1; run(1); up = 1'b0; run(6);
        end
        // let the counter run close to the end of a long period, then normal
        run(3400);
        normal = 1'b1; run(1); up = 1'b1; run(1); up = 1'b0; run(1); normal = 1'b0;
        run(2 * NOM);

        // down held long enough to auto-repeat into the lower bound
        down = 1'b1; run(30); down = 1'b0; run(10);

        // both held, then one released: repeat restarts from zero
        normal = 1'b1; run(4); normal = 1'b0; run(4);
        up = 1'b1; down = 1'b1; run(20); down = 1'b0; run(15); up = 1'b0; run(5);

        // reset in the middle of a period at the lower bound
        down = 1'b1; run(20); down = 1'b0; run(1000);
        mid_reset();
        run(NOM + 10);

        for (int s = 0; s < 250; s++) begin
            random_segment();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
